// File: rtl/sv_status_seq.sv
// Job status sequencer: tracks a single job through IDLE/BUSY/DONE/ERROR and
// holds the terminal status, remaining step count and error cause until cleared.
module sv_status_seq #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             step_valid,
  input  logic             abort,
  input  logic             clear,
  output logic [1:0]       state_out,
  output logic [CNT_W-1:0] remaining,
  output logic [1:0]       err_code,
  output logic             done_pulse,
  output logic             err_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUSY  = 2'b01,
    ST_DONE  = 2'b10,
    ST_ERROR = 2'b11
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ABORT   = 2'b10;
  localparam logic [1:0] ERR_ZERO    = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [15:0]      IDLE_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0]      IDLE_MAX  = 16'hFFFF;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             done_pulse_q, done_pulse_d;
  logic             err_pulse_q, err_pulse_d;
  logic [15:0]      idle_cnt_q, idle_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      remaining_q  <= CNT_ZERO;
      err_code_q   <= ERR_NONE;
      done_pulse_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      idle_cnt_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      err_code_q   <= err_code_d;
      done_pulse_q <= done_pulse_d;
      err_pulse_q  <= err_pulse_d;
      idle_cnt_q   <= idle_cnt_d;
    end
  end

  // Pulses default low so they last only for the edge that enters DONE/ERROR.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    err_code_d   = err_code_q;
    done_pulse_d = 1'b0;
    err_pulse_d  = 1'b0;
    idle_cnt_d   = idle_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len != CNT_ZERO) begin
            state_d     = ST_BUSY;
            remaining_d = len;
            idle_cnt_d  = 16'd0;
            err_code_d  = ERR_NONE;
          end else begin
            state_d     = ST_ERROR;
            err_code_d  = ERR_ZERO;
            err_pulse_d = 1'b1;
          end
        end
      end

      ST_BUSY: begin
        if (abort) begin
          state_d     = ST_ERROR;
          err_code_d  = ERR_ABORT;
          err_pulse_d = 1'b1;
        end else if (step_valid) begin
          remaining_d = remaining_q - CNT_ONE;
          idle_cnt_d  = 16'd0;
          if (remaining_q == CNT_ONE) begin
            state_d      = ST_DONE;
            done_pulse_d = 1'b1;
          end
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d     = ST_ERROR;
          err_code_d  = ERR_TIMEOUT;
          err_pulse_d = 1'b1;
        end else if (idle_cnt_q != IDLE_MAX) begin
          idle_cnt_d = idle_cnt_q + 16'd1;
        end
      end

      // Terminal states wait for software; a start alongside clear is dropped.
      ST_DONE, ST_ERROR: begin
        if (clear) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign state_out  = state_q;
  assign remaining  = remaining_q;
  assign err_code   = err_code_q;
  assign done_pulse = done_pulse_q;
  assign err_pulse  = err_pulse_q;

endmodule

// File: tb/tb_sv_status_seq.sv
// Directed self-checking bench for sv_status_seq with a short timeout (8)
// so stall detection can be exercised in a handful of cycles.
module tb_sv_status_seq;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             step_valid;
  logic             abort;
  logic             clear;
  logic [1:0]       state_out;
  logic [CNT_W-1:0] remaining;
  logic [1:0]       err_code;
  logic             done_pulse;
  logic             err_pulse;

  int errors = 0;
  int checks = 0;

  sv_status_seq #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .step_valid (step_valid),
    .abort      (abort),
    .clear      (clear),
    .state_out  (state_out),
    .remaining  (remaining),
    .err_code   (err_code),
    .done_pulse (done_pulse),
    .err_pulse  (err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sets inputs, lets one rising edge pass, then settles 1 time unit after it.
  task automatic applyStimulus(input logic r, input logic s, input logic [CNT_W-1:0] l,
                               input logic sv, input logic ab, input logic cl);
    rst = r; start = s; len = l; step_valid = sv; abort = ab; clear = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [1:0] st, input logic [CNT_W-1:0] rem,
                          input logic [1:0] ec, input logic dp, input logic ep);
    checkOutput({tag, ".state"}, 32'(state_out), 32'(st));
    checkOutput({tag, ".remaining"}, 32'(remaining), 32'(rem));
    checkOutput({tag, ".err_code"}, 32'(err_code), 32'(ec));
    checkOutput({tag, ".done_pulse"}, 32'(done_pulse), 32'(dp));
    checkOutput({tag, ".err_pulse"}, 32'(err_pulse), 32'(ep));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; step_valid = 1'b0; abort = 1'b0; clear = 1'b0;
    #2;

    // Reset held two cycles with start asserted
    applyStimulus(1, 1, 8'd7, 0, 0, 0);
    applyStimulus(1, 1, 8'd7, 0, 0, 0);
    checkAll("reset", 2'b00, 8'd0, 2'b00, 0, 0);

    // Release reset: start still high loads len
    applyStimulus(0, 1, 8'd7, 0, 0, 0);
    checkAll("rst_release", 2'b01, 8'd7, 2'b00, 0, 0);

    // Four steps down to 3, then mid-job reset
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 8'd0, 1, 0, 0);
    checkAll("pre_midrst", 2'b01, 8'd3, 2'b00, 0, 0);
    applyStimulus(1, 0, 8'd0, 1, 0, 0);
    checkAll("midrst", 2'b00, 8'd0, 2'b00, 0, 0);

    // Normal job of 5 with step_valid held high
    applyStimulus(0, 1, 8'd5, 1, 0, 0);
    checkAll("norm_load", 2'b01, 8'd5, 2'b00, 0, 0);
    for (int r = 4; r >= 1; r--) begin
      applyStimulus(0, 0, 8'd0, 1, 0, 0);
      checkAll("norm_count", 2'b01, 8'(r), 2'b00, 0, 0);
    end
    applyStimulus(0, 0, 8'd0, 1, 0, 0);
    checkAll("norm_done", 2'b10, 8'd0, 2'b00, 1, 0);
    applyStimulus(0, 1, 8'd9, 1, 0, 0);
    checkAll("norm_hold", 2'b10, 8'd0, 2'b00, 0, 0);
    applyStimulus(0, 0, 8'd0, 0, 0, 1);
    checkAll("norm_clear", 2'b00, 8'd0, 2'b00, 0, 0);

    // Timeout: len 3, one step, then stall
    applyStimulus(0, 1, 8'd3, 0, 0, 0);
    checkAll("to_load", 2'b01, 8'd3, 2'b00, 0, 0);
    applyStimulus(0, 0, 8'd0, 1, 0, 0);
    checkAll("to_step", 2'b01, 8'd2, 2'b00, 0, 0);
    for (int i = 0; i < TIMEOUT - 1; i++) applyStimulus(0, 0, 8'd0, 0, 0, 0);
    checkAll("to_before", 2'b01, 8'd2, 2'b00, 0, 0);
    applyStimulus(0, 0, 8'd0, 0, 0, 0);
    checkAll("to_err", 2'b11, 8'd2, 2'b01, 0, 1);
    applyStimulus(0, 0, 8'd0, 0, 0, 0);
    checkAll("to_hold", 2'b11, 8'd2, 2'b01, 0, 0);
    applyStimulus(0, 0, 8'd0, 0, 0, 1);
    checkAll("to_clear", 2'b00, 8'd2, 2'b01, 0, 0);

    // Abort wins over step; start during BUSY ignored
    applyStimulus(0, 1, 8'd6, 0, 0, 0);
    checkAll("ab_load", 2'b01, 8'd6, 2'b00, 0, 0);
    applyStimulus(0, 0, 8'd0, 1, 0, 0);
    applyStimulus(0, 0, 8'd0, 1, 0, 0);
    applyStimulus(0, 1, 8'd9, 0, 0, 1);
    checkAll("busy_start", 2'b01, 8'd4, 2'b00, 0, 0);
    applyStimulus(0, 0, 8'd0, 1, 1, 0);
    checkAll("ab_err", 2'b11, 8'd4, 2'b10, 0, 1);

    // Clear together with start: IDLE, no new job
    applyStimulus(0, 1, 8'd5, 0, 0, 1);
    checkAll("clr_start", 2'b00, 8'd4, 2'b10, 0, 0);
    applyStimulus(0, 0, 8'd0, 1, 1, 1);
    checkAll("idle_ignore", 2'b00, 8'd4, 2'b10, 0, 0);

    // Zero-length start
    applyStimulus(0, 1, 8'd0, 0, 0, 0);
    checkAll("zero_len", 2'b11, 8'd4, 2'b11, 0, 1);
    applyStimulus(0, 0, 8'd0, 0, 0, 1);
    checkAll("zero_clear", 2'b00, 8'd4, 2'b11, 0, 0);

    // Fresh start clears err_code; single-step job finishes next cycle
    applyStimulus(0, 1, 8'd1, 0, 0, 0);
    checkAll("restart", 2'b01, 8'd1, 2'b00, 0, 0);
    applyStimulus(0, 0, 8'd0, 1, 0, 0);
    checkAll("one_step", 2'b10, 8'd0, 2'b00, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
